param_seq_detector: RTL and testbench

Parametrised Moore-style serial sequence detector and the successor to the fixed-pattern detector FSMs. The pattern, its length and the overlap mode are loaded at run time, and serial bits are qualified by a valid strobe. A saturating match counter is provided. It sits on a serial bit stream and flags pattern occurrences to downstream control logic.

---
 rtl/param_seq_detector_if.sv | 45 ++++
 rtl/param_seq_detector.sv | 142 ++++++++++++++
 tb/tb_param_seq_detector.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/param_seq_detector_if.sv
// ---------------------------------------------------------------------------
// param_seq_detector_if
//   Groups the configuration, serial-input and result signals of the
//   parametrised sequence detector.
//
//   cfg_load     load pattern/length/mode this cycle
//   cfg_pattern  pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len      pattern length, legal 1..PAT_W
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   din_valid    d carries a valid serial bit this cycle
//   d            serial data bit
//   y            registered one-cycle match pulse
//   match_count  saturating match counter
//   armed        a legal configuration is held
//   cfg_err      sticky illegal-length flag
//
//   master: the side that configures the detector and feeds bits.
//   slave : the detector itself.
// ---------------------------------------------------------------------------
interface param_seq_detector_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             din_valid;
    logic             d;
    logic             y;
    logic [CNT_W-1:0] match_count;
    logic             armed;
    logic             cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, d,
        input  y, match_count, armed, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, d,
        output y, match_count, armed, cfg_err
    );
endinterface

// File: rtl/param_seq_detector.sv
// ---------------------------------------------------------------------------
// param_seq_detector
//   Moore-style serial sequence detector with a run-time loadable pattern,
//   length and overlap mode. Valid-qualified serial bits are shifted into a
//   history window; when at least len fresh bits have arrived and the newest
//   len bits equal the stored pattern, y pulses for one cycle (one clock after
//   the completing bit is sampled) and a saturating counter increments.
//
//   clk    rising-edge clock
//   reset  synchronous reset, active low
//   bus    param_seq_detector_if slave modport (config, serial in, results)
// ---------------------------------------------------------------------------
module param_seq_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    param_seq_detector_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t             state_q, state_d;
    // Only PAT_W-1 past bits are kept: together with the incoming bit they
    // form the full PAT_W-bit window that the longest pattern is compared to.
    logic [PAT_W-2:0]   hist_q,  hist_d;
    logic [LEN_W-1:0]   fresh_q, fresh_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic               ovl_q,   ovl_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;
    logic               y_q,     y_d;

    logic [PAT_W-1:0]   new_hist;
    logic [PAT_W-1:0]   len_mask;
    logic [LEN_W-1:0]   fresh_inc;
    logic               len_ok;
    logic               hit;

    // Low len_q bits set; pattern bits above len-1 never take part in a match.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        new_hist  = {hist_q, bus.d};
        fresh_inc = (fresh_q >= LEN_MAX) ? LEN_MAX : fresh_q + 1'b1;
        len_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
        // Evaluated on the post-shift history and post-increment fresh count,
        // so the bit arriving this cycle can complete a match.
        hit       = (fresh_inc >= len_q) &&
                    (((new_hist ^ pat_q) & len_mask) == '0);
    end

    // Next-state / output logic
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fresh_d = fresh_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        y_d     = 1'b0;

        if (bus.cfg_load) begin
            // A load always restarts detection; any bit presented in the
            // same cycle is dropped.
            hist_d  = '0;
            fresh_d = '0;
            if (len_ok) begin
                state_d = ARMED;
                pat_d   = bus.cfg_pattern;
                len_d   = bus.cfg_len;
                ovl_d   = bus.cfg_overlap;
                cnt_d   = '0;
                err_d   = 1'b0;
            end else begin
                state_d = IDLE;
                pat_d   = '0;
                len_d   = '0;
                ovl_d   = 1'b0;
                err_d   = 1'b1;
            end
        end else if (state_q == ARMED && bus.din_valid) begin
            hist_d  = new_hist[PAT_W-2:0];
            fresh_d = fresh_inc;
            if (hit) begin
                y_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping: the next match must be built from len new bits.
                if (!ovl_q) begin
                    fresh_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fresh_q <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fresh_q <= fresh_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            y_q     <= y_d;
        end
    end

    assign bus.y           = y_q;
    assign bus.match_count = cnt_q;
    assign bus.armed       = (state_q == ARMED);
    assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_param_seq_detector
//   Two detectors share one stimulus stream: dut1 with an 8-bit counter and
//   dut2 with a 2-bit counter (its expected count is the table count clamped
//   at 3). Each step drives one cycle of inputs, queues the expected outputs
//   and pops/compares them one clock later.
// ---------------------------------------------------------------------------
module tb_param_seq_detector;
    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus1 ();
    param_seq_detector_if #(.PAT_W(PAT_W), .CNT_W(2))     bus2 ();

    assign bus2.cfg_load    = bus1.cfg_load;
    assign bus2.cfg_pattern = bus1.cfg_pattern;
    assign bus2.cfg_len     = bus1.cfg_len;
    assign bus2.cfg_overlap = bus1.cfg_overlap;
    assign bus2.din_valid   = bus1.din_valid;
    assign bus2.d           = bus1.d;

    param_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );
    param_seq_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    typedef struct {
        string            tag;
        logic             rst_n;
        logic             load;
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic             ovl;
        logic             vld;
        logic             d;
        logic             ey;
        int               ecnt;
        logic             earm;
        logic             eerr;
    } vec_t;

    typedef struct {
        string tag;
        logic  ey;
        int    ecnt;
        logic  earm;
        logic  eerr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(string t, logic r, logic ld, logic [PAT_W-1:0] p,
                                logic [LEN_W-1:0] l, logic o, logic v, logic dd,
                                logic ey, int c, logic a, logic e);
        vec_t x;
        x.tag = t; x.rst_n = r; x.load = ld; x.pat = p; x.len = l; x.ovl = o;
        x.vld = v; x.d = dd; x.ey = ey; x.ecnt = c; x.earm = a; x.eerr = e;
        return x;
    endfunction

    function automatic vec_t RST(string t);
        return mk(t, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    // Load; count after any load in this bench is 0.
    function automatic vec_t LD(string t, logic [PAT_W-1:0] p, logic [LEN_W-1:0] l,
                                logic o, logic a, logic e);
        return mk(t, 1'b1, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0, 0, a, e);
    endfunction

    // Valid bit while armed with no error.
    function automatic vec_t BIT(string t, logic dd, logic ey, int c);
        return mk(t, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, dd, ey, c, 1'b1, 1'b0);
    endfunction

    // Valid bit while idle with the error flag set.
    function automatic vec_t IBIT(string t, logic dd);
        return mk(t, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, dd, 1'b0, 0, 1'b0, 1'b1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset            = v.rst_n;
        bus1.cfg_load    = v.load;
        bus1.cfg_pattern = v.pat;
        bus1.cfg_len     = v.len;
        bus1.cfg_overlap = v.ovl;
        bus1.din_valid   = v.vld;
        bus1.d           = v.d;
        e.tag = v.tag; e.ey = v.ey; e.ecnt = v.ecnt; e.earm = v.earm; e.eerr = v.eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".y1"},     32'(bus1.y),           32'(e.ey));
            chk({e.tag, ".cnt1"},   32'(bus1.match_count), 32'(e.ecnt));
            chk({e.tag, ".armed1"}, 32'(bus1.armed),       32'(e.earm));
            chk({e.tag, ".err1"},   32'(bus1.cfg_err),     32'(e.eerr));
            chk({e.tag, ".y2"},     32'(bus2.y),           32'(e.ey));
            chk({e.tag, ".cnt2"},   32'(bus2.match_count), 32'((e.ecnt > 3) ? 3 : e.ecnt));
            chk({e.tag, ".armed2"}, 32'(bus2.armed),       32'(e.earm));
            chk({e.tag, ".err2"},   32'(bus2.cfg_err),     32'(e.eerr));
        end
    endtask

    logic gbits [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic gys   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int c;
        reset = 1'b0;
        bus1.cfg_load = 1'b0; bus1.cfg_pattern = '0; bus1.cfg_len = '0;
        bus1.cfg_overlap = 1'b0; bus1.din_valid = 1'b0; bus1.d = 1'b0;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(RST("rst")); tbl.push_back(RST("rst"));
        // overlap on: 1011 in stream 1,0,1,1,0,1,1
        tbl.push_back(LD("ovl_ld", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        tbl.push_back(BIT("ovl", 1, 0, 0)); tbl.push_back(BIT("ovl", 0, 0, 0));
        tbl.push_back(BIT("ovl", 1, 0, 0)); tbl.push_back(BIT("ovl", 1, 1, 1));
        tbl.push_back(BIT("ovl", 0, 0, 1)); tbl.push_back(BIT("ovl", 1, 0, 1));
        tbl.push_back(BIT("ovl", 1, 1, 2));
        tbl.push_back(mk("ovl_idle", 1, 0, '0, '0, 0, 0, 0, 0, 2, 1, 0));
        // overlap off: same stream, only one match
        tbl.push_back(LD("nov_ld", 8'h0B, 4, 1'b0, 1'b1, 1'b0));
        tbl.push_back(BIT("nov", 1, 0, 0)); tbl.push_back(BIT("nov", 0, 0, 0));
        tbl.push_back(BIT("nov", 1, 0, 0)); tbl.push_back(BIT("nov", 1, 1, 1));
        tbl.push_back(BIT("nov", 0, 0, 1)); tbl.push_back(BIT("nov", 1, 0, 1));
        tbl.push_back(BIT("nov", 1, 0, 1));
        // len=1, pattern[0]=0, upper pattern bits set and ignored
        tbl.push_back(LD("len1_ld", 8'hFE, 1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(BIT("len1", 0, 1, 1)); tbl.push_back(BIT("len1", 1, 0, 1));
        tbl.push_back(BIT("len1", 0, 1, 2)); tbl.push_back(BIT("len1", 0, 1, 3));
        // len=PAT_W, overlapping re-match of 10100101
        tbl.push_back(LD("len8_ld", 8'hA5, 8, 1'b1, 1'b1, 1'b0));
        tbl.push_back(BIT("len8", 1, 0, 0)); tbl.push_back(BIT("len8", 0, 0, 0));
        tbl.push_back(BIT("len8", 1, 0, 0)); tbl.push_back(BIT("len8", 0, 0, 0));
        tbl.push_back(BIT("len8", 0, 0, 0)); tbl.push_back(BIT("len8", 1, 0, 0));
        tbl.push_back(BIT("len8", 0, 0, 0)); tbl.push_back(BIT("len8", 1, 1, 1));
        tbl.push_back(BIT("len8", 0, 0, 1)); tbl.push_back(BIT("len8", 0, 0, 1));
        tbl.push_back(BIT("len8", 1, 0, 1)); tbl.push_back(BIT("len8", 0, 0, 1));
        tbl.push_back(BIT("len8", 1, 1, 2));
        // load together with a valid bit: bit dropped, history cleared
        tbl.push_back(LD("ldv_ld", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        tbl.push_back(BIT("ldv", 1, 0, 0)); tbl.push_back(BIT("ldv", 0, 0, 0));
        tbl.push_back(BIT("ldv", 1, 0, 0));
        tbl.push_back(mk("ldv_both", 1, 1, 8'h0B, 4, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(BIT("ldv", 1, 0, 0)); tbl.push_back(BIT("ldv", 0, 0, 0));
        tbl.push_back(BIT("ldv", 1, 0, 0)); tbl.push_back(BIT("ldv", 1, 1, 1));
        // illegal lengths
        tbl.push_back(RST("ill_rst"));
        tbl.push_back(LD("bad0", 8'h0B, 0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(IBIT("bad0", 1)); tbl.push_back(IBIT("bad0", 0));
        tbl.push_back(IBIT("bad0", 1)); tbl.push_back(IBIT("bad0", 1));
        tbl.push_back(LD("bad9", 8'h0B, 9, 1'b1, 1'b0, 1'b1));
        tbl.push_back(IBIT("bad9", 1)); tbl.push_back(IBIT("bad9", 0));
        tbl.push_back(IBIT("bad9", 1)); tbl.push_back(IBIT("bad9", 1));
        tbl.push_back(LD("good", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        tbl.push_back(LD("bad_armed", 8'h0B, 9, 1'b1, 1'b0, 1'b1));
        tbl.push_back(IBIT("bad_armed", 1));
        tbl.push_back(LD("good2", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        tbl.push_back(BIT("good2", 1, 0, 0)); tbl.push_back(BIT("good2", 0, 0, 0));
        tbl.push_back(BIT("good2", 1, 0, 0)); tbl.push_back(BIT("good2", 1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // ---------------- valid gaps ----------------
        apply(LD("gap_ld", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        c = 0;
        for (int i = 0; i < 7; i++) begin
            if (gys[i]) c++;
            apply(BIT("gap", gbits[i], gys[i], c));
            for (int g = 0; g < 3; g++)
                apply(mk("gap_idle", 1, 0, '0, '0, 0, 0, 1'($urandom_range(1)), 0, c, 1, 0));
        end

        // ---------------- reset mid-pattern ----------------
        apply(LD("mid_ld", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        apply(BIT("mid", 1, 0, 0)); apply(BIT("mid", 0, 0, 0)); apply(BIT("mid", 1, 0, 0));
        apply(RST("mid_rst"));
        apply(LD("mid_reld", 8'h0B, 4, 1'b1, 1'b1, 1'b0));
        apply(BIT("mid2", 1, 0, 0)); apply(BIT("mid2", 0, 0, 0));
        apply(BIT("mid2", 1, 0, 0)); apply(BIT("mid2", 1, 1, 1));
        apply(mk("mid_idle", 1, 0, '0, '0, 0, 0, 0, 0, 1, 1, 0));

        // ---------------- saturation (dut2 clamps at 3) ----------------
        apply(RST("sat_rst"));
        apply(LD("sat_ld", 8'h01, 1, 1'b0, 1'b1, 1'b0));
        for (int k = 1; k <= 6; k++) apply(BIT("sat", 1, 1, k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
